binary_window_3x3: RTL and testbench

Streaming 3x3 neighbourhood generator for single-bit (binarised) image data. It takes one pixel per valid beat in raster order and stores the two previous rows in two single-bit line RAMs. For every input pixel that completes a full 3x3 neighbourhood, it emits all nine bits together. It feeds the morphology/labelling stages and is the direct consumer and driver of the line-buffer RAM.

---
 rtl/image_pkg.sv | 23 ++
 rtl/bit_line_ram.sv | 48 ++++
 rtl/binary_window_3x3.sv | 128 ++++++++++++
 tb/tb_binary_window_3x3.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared constants for the binary 3x3 window pipeline: default frame geometry and
// the bit positions of each neighbour inside the 9-bit window.
package image_pkg;

    localparam int unsigned DefImageWidth  = 640;
    localparam int unsigned DefImageHeight = 480;
    localparam int unsigned DefAddrWidth   = 10;
    localparam int unsigned DefRowWidth    = 9;

    localparam int unsigned WinBits = 9;

    // Window bit 3*r+k: r=0 is the oldest row (y-2), k=0 is the oldest column (x-2).
    localparam int unsigned WIN_TL = 0;
    localparam int unsigned WIN_TC = 1;
    localparam int unsigned WIN_TR = 2;
    localparam int unsigned WIN_ML = 3;
    localparam int unsigned WIN_C  = 4;
    localparam int unsigned WIN_MR = 5;
    localparam int unsigned WIN_BL = 6;
    localparam int unsigned WIN_BC = 7;
    localparam int unsigned WIN_BR = 8;

endpackage

// File: rtl/bit_line_ram.sv
// Single-bit line RAM: one-cycle synchronous read-first port plus a write port whose
// address/data are registered one cycle before they commit to the array.
module bit_line_ram #(
    parameter int unsigned Depth     = 640,
    parameter int unsigned AddrWidth = 10
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 re_i,
    input  logic [AddrWidth-1:0] raddr_i,
    output logic                 rdata_o,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] waddr_i,
    input  logic                 wdata_i
);

    logic                 mem_q [Depth];
    logic                 wreq_q;
    logic [AddrWidth-1:0] waddr_q;
    logic                 wdata_q;
    logic                 rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wreq_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= 1'b0;
            rdata_q <= 1'b0;
        end else begin
            wreq_q  <= we_i;
            waddr_q <= waddr_i;
            wdata_q <= wdata_i;
            if (re_i) begin
                rdata_q <= mem_q[raddr_i];
            end
        end
    end

    // Array is deliberately unreset; a read on the commit edge sees the old value.
    always_ff @(posedge clk_i) begin
        if (wreq_q) begin
            mem_q[waddr_q] <= wdata_q;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/binary_window_3x3.sv
// Streaming 3x3 neighbourhood generator for binary pixels: raster counters, two line
// RAMs holding rows y-1/y-2, and a two-stage pipeline ending in a column shift register.
module binary_window_3x3
    import image_pkg::*;
#(
    parameter int unsigned ImageWidth  = DefImageWidth,
    parameter int unsigned ImageHeight = DefImageHeight,
    parameter int unsigned AddrWidth   = DefAddrWidth,
    parameter int unsigned RowWidth    = DefRowWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    input  logic                 in_pixel_i,
    output logic                 out_valid_o,
    output logic [WinBits-1:0]   window_o,
    output logic [AddrWidth-1:0] out_x_o,
    output logic [RowWidth-1:0]  out_y_o,
    output logic                 out_last_o
);

    localparam logic [AddrWidth-1:0] ColMax = AddrWidth'(ImageWidth - 1);
    localparam logic [RowWidth-1:0]  RowMax = RowWidth'(ImageHeight - 1);

    logic [AddrWidth-1:0] col_q, col_d, col1_q;
    logic [RowWidth-1:0]  row_q, row_d, row1_q;
    logic                 v1_q, pix1_q;
    logic                 rd_a, rd_b;
    logic [WinBits-1:0]   sr_q, sr_d, window_q;
    logic [AddrWidth-1:0] out_x_q;
    logic [RowWidth-1:0]  out_y_q;
    logic                 out_valid_q, out_last_q;
    logic                 emit, last_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (in_valid_i) begin
            if (col_q == ColMax) begin
                col_d = '0;
                row_d = (row_q == RowMax) ? '0 : row_q + RowWidth'(1);
            end else begin
                col_d = col_q + AddrWidth'(1);
            end
        end
    end

    // Row y-1: read old value at x, then overwrite it with the incoming pixel.
    bit_line_ram #(
        .Depth     (ImageWidth),
        .AddrWidth (AddrWidth)
    ) u_ram_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (in_valid_i),
        .raddr_i (col_q),
        .rdata_o (rd_a),
        .we_i    (in_valid_i),
        .waddr_i (col_q),
        .wdata_i (in_pixel_i)
    );

    // Row y-2: fed from RAM A's read data once it arrives in stage 1.
    bit_line_ram #(
        .Depth     (ImageWidth),
        .AddrWidth (AddrWidth)
    ) u_ram_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .re_i    (in_valid_i),
        .raddr_i (col_q),
        .rdata_o (rd_b),
        .we_i    (v1_q),
        .waddr_i (col1_q),
        .wdata_i (rd_a)
    );

    always_comb begin
        sr_d = sr_q;
        if (v1_q) begin
            sr_d = {pix1_q, sr_q[WIN_BR:WIN_BC], rd_a, sr_q[WIN_MR:WIN_C],
                    rd_b, sr_q[WIN_TR:WIN_TC]};
        end
        emit   = v1_q && (col1_q >= AddrWidth'(2)) && (row1_q >= RowWidth'(2));
        last_d = (col1_q == ColMax) && (row1_q == RowMax);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q       <= '0;
            row_q       <= '0;
            v1_q        <= 1'b0;
            pix1_q      <= 1'b0;
            col1_q      <= '0;
            row1_q      <= '0;
            sr_q        <= '0;
            out_valid_q <= 1'b0;
            window_q    <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            v1_q        <= in_valid_i;
            if (in_valid_i) begin
                pix1_q <= in_pixel_i;
                col1_q <= col_q;
                row1_q <= row_q;
            end
            sr_q        <= sr_d;
            out_valid_q <= emit;
            if (emit) begin
                window_q   <= sr_d;
                out_x_q    <= col1_q - AddrWidth'(1);
                out_y_q    <= row1_q - RowWidth'(1);
                out_last_q <= last_d;
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign window_o    = window_q;
    assign out_x_o     = out_x_q;
    assign out_y_o     = out_y_q;
    assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_binary_window_3x3.sv
// Self-checking bench for binary_window_3x3: an 8x4 and a 3x3 instance driven with
// random frames and gaps, checked against a neighbourhood model built from the image array.
module tb_binary_window_3x3;

    localparam int W8 = 8;
    localparam int H8 = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       v8 = 1'b0, p8 = 1'b0, v3 = 1'b0, p3 = 1'b0;
    logic       ov8, ol8, ov3, ol3;
    logic [8:0] win8, win3;
    logic [2:0] ox8;
    logic [1:0] oy8, ox3, oy3;

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {logic [8:0] win; int x; int y; logic last; int cyc;} rec_t;
    typedef struct {logic [8:0] win; int x; int y; logic last; int idx;} exp_t;

    rec_t got8[$], got3[$], ref8[$];
    int   beat8[$], beat3[$];
    exp_t exp_q[$];
    bit   img [0:3][0:7];

    binary_window_3x3 #(
        .ImageWidth (W8),
        .ImageHeight(H8),
        .AddrWidth  (3),
        .RowWidth   (2)
    ) dut8 (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (v8),
        .in_pixel_i (p8),
        .out_valid_o(ov8),
        .window_o   (win8),
        .out_x_o    (ox8),
        .out_y_o    (oy8),
        .out_last_o (ol8)
    );

    binary_window_3x3 #(
        .ImageWidth (3),
        .ImageHeight(3),
        .AddrWidth  (2),
        .RowWidth   (2)
    ) dut3 (
        .clk_i      (clk),
        .rst_i      (rst),
        .in_valid_i (v3),
        .in_pixel_i (p3),
        .out_valid_o(ov3),
        .window_o   (win3),
        .out_x_o    (ox3),
        .out_y_o    (oy3),
        .out_last_o (ol3)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (v8) beat8.push_back(cyc);
            if (v3) beat3.push_back(cyc);
            if (ov8) got8.push_back('{win: win8, x: int'(ox8), y: int'(oy8), last: ol8, cyc: cyc});
            if (ov3) got3.push_back('{win: win3, x: int'(ox3), y: int'(oy3), last: ol3, cyc: cyc});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Expected windows straight from the image: every pixel with x>=2, y>=2 yields one.
    task automatic build_model(input int w, input int h);
        exp_t e;
        exp_q.delete();
        for (int y = 2; y < h; y++) begin
            for (int x = 2; x < w; x++) begin
                e.win = '0;
                for (int r = 0; r < 3; r++)
                    for (int k = 0; k < 3; k++)
                        e.win[3*r+k] = img[y-2+r][x-2+k];
                e.x    = x - 1;
                e.y    = y - 1;
                e.last = (x == w - 1) && (y == h - 1);
                e.idx  = y * w + x;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input int n);
        v8 = 1'b0;
        v3 = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Gap mode always idles before column 0, so some gaps straddle a row end.
    task automatic drive_frame(input bit sel3, input int gap_pct, input int nbeats);
        int w = sel3 ? 3 : W8;
        for (int i = 0; i < nbeats; i++) begin
            int x = i % w;
            int y = i / w;
            if (gap_pct > 0 && (x == 0 || $urandom_range(0, 99) < gap_pct))
                idle($urandom_range(1, 3));
            if (sel3) begin
                v3 = 1'b1;
                p3 = img[y][x];
            end else begin
                v8 = 1'b1;
                p8 = img[y][x];
            end
            @(posedge clk);
            #1;
        end
        v8 = 1'b0;
        v3 = 1'b0;
    endtask

    task automatic fill_random();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 1'($urandom_range(0, 1));
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({ov8, win8, ox8, oy8, ol8} !== '0) begin
            n_err++;
            $display("FAIL reset8: got v=%b w=%h x=%0d y=%0d l=%b want all 0", ov8, win8, ox8, oy8, ol8);
        end
        n_vec++;
        if ({ov3, win3, ox3, oy3, ol3} !== '0) begin
            n_err++;
            $display("FAIL reset3: got v=%b w=%h x=%0d y=%0d l=%b want all 0", ov3, win3, ox3, oy3, ol3);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_all_ones();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 1'b1;
        build_model(W8, H8);
        got8.delete();
        beat8.delete();
        drive_frame(1'b0, 0, W8 * H8);
        idle(6);
        n_vec++;
        if (got8.size() != 12) begin
            n_err++;
            $display("FAIL all_ones count: got %0d want 12", got8.size());
        end
        foreach (exp_q[i]) begin
            if (i < got8.size()) begin
                int want = (exp_q[i].idx < beat8.size()) ? beat8[exp_q[i].idx] + 2 : -1;
                n_vec++;
                if (got8[i].win !== 9'h1FF || got8[i].x != exp_q[i].x || got8[i].y != exp_q[i].y ||
                    got8[i].last !== exp_q[i].last || got8[i].cyc != want) begin
                    n_err++;
                    $display("FAIL all_ones[%0d]: got w=%h (%0d,%0d) l=%b t=%0d want w=1ff (%0d,%0d) l=%b t=%0d",
                             i, got8[i].win, got8[i].x, got8[i].y, got8[i].last, got8[i].cyc,
                             exp_q[i].x, exp_q[i].y, exp_q[i].last, want);
                end
            end
        end
    endtask

    task automatic test_single_one();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 1'b0;
        img[1][3] = 1'b1;
        build_model(W8, H8);
        got8.delete();
        beat8.delete();
        drive_frame(1'b0, 0, W8 * H8);
        idle(6);
        n_vec++;
        if (got8.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL single_one count: got %0d want %0d", got8.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got8.size()) begin
                n_vec++;
                if (got8[i].win !== exp_q[i].win || got8[i].x != exp_q[i].x || got8[i].y != exp_q[i].y) begin
                    n_err++;
                    $display("FAIL single_one[%0d]: got w=%h (%0d,%0d) want w=%h (%0d,%0d)", i,
                             got8[i].win, got8[i].x, got8[i].y, exp_q[i].win, exp_q[i].x, exp_q[i].y);
                end
            end
        end
    endtask

    task automatic test_random_gaps();
        fill_random();
        build_model(W8, H8);
        got8.delete();
        beat8.delete();
        drive_frame(1'b0, 0, W8 * H8);
        idle(6);
        ref8 = got8;
        n_vec++;
        if (ref8.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL gaps_cont count: got %0d want %0d", ref8.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < ref8.size()) begin
                n_vec++;
                if (ref8[i].win !== exp_q[i].win || ref8[i].last !== exp_q[i].last) begin
                    n_err++;
                    $display("FAIL gaps_cont[%0d]: got w=%h l=%b want w=%h l=%b", i,
                             ref8[i].win, ref8[i].last, exp_q[i].win, exp_q[i].last);
                end
            end
        end
        got8.delete();
        beat8.delete();
        drive_frame(1'b0, 35, W8 * H8);
        idle(6);
        n_vec++;
        if (got8.size() != ref8.size()) begin
            n_err++;
            $display("FAIL gaps count: got %0d want %0d", got8.size(), ref8.size());
        end
        foreach (ref8[i]) begin
            if (i < got8.size() && i < exp_q.size()) begin
                int want = (exp_q[i].idx < beat8.size()) ? beat8[exp_q[i].idx] + 2 : -1;
                n_vec++;
                if (got8[i].win !== ref8[i].win || got8[i].x != ref8[i].x || got8[i].y != ref8[i].y ||
                    got8[i].cyc != want) begin
                    n_err++;
                    $display("FAIL gaps[%0d]: got w=%h (%0d,%0d) t=%0d want w=%h (%0d,%0d) t=%0d", i,
                             got8[i].win, got8[i].x, got8[i].y, got8[i].cyc,
                             ref8[i].win, ref8[i].x, ref8[i].y, want);
                end
            end
        end
    endtask

    task automatic test_two_frames();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 1'((x + y) & 1);
        build_model(W8, H8);
        got8.delete();
        beat8.delete();
        drive_frame(1'b0, 0, W8 * H8);
        drive_frame(1'b0, 0, W8 * H8);
        idle(6);
        n_vec++;
        if (got8.size() != 2 * exp_q.size()) begin
            n_err++;
            $display("FAIL two_frames count: got %0d want %0d", got8.size(), 2 * exp_q.size());
        end
        for (int i = 0; i < got8.size() && i < 2 * exp_q.size(); i++) begin
            int j    = i % exp_q.size();
            int bi   = exp_q[j].idx + ((i >= exp_q.size()) ? W8 * H8 : 0);
            int want = (bi < beat8.size()) ? beat8[bi] + 2 : -1;
            n_vec++;
            if (got8[i].win !== exp_q[j].win || got8[i].x != exp_q[j].x || got8[i].y != exp_q[j].y ||
                got8[i].last !== exp_q[j].last || got8[i].cyc != want) begin
                n_err++;
                $display("FAIL two_frames[%0d]: got w=%h (%0d,%0d) l=%b t=%0d want w=%h (%0d,%0d) l=%b t=%0d",
                         i, got8[i].win, got8[i].x, got8[i].y, got8[i].last, got8[i].cyc,
                         exp_q[j].win, exp_q[j].x, exp_q[j].y, exp_q[j].last, want);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        fill_random();
        drive_frame(1'b0, 0, 2 * W8 + 5);
        v8  = 1'b1;
        p8  = img[2][5];
        rst = 1'b1;
        #1;
        n_vec++;
        if (ov8 !== 1'b0 || win8 !== '0) begin
            n_err++;
            $display("FAIL mid_reset outputs: got v=%b w=%h want v=0 w=000", ov8, win8);
        end
        @(posedge clk);
        #1;
        v8  = 1'b0;
        rst = 1'b0;
        got8.delete();
        beat8.delete();
        fill_random();
        build_model(W8, H8);
        drive_frame(1'b0, 0, W8 * H8);
        idle(6);
        n_vec++;
        if (got8.size() != exp_q.size()) begin
            n_err++;
            $display("FAIL mid_reset count: got %0d want %0d", got8.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            if (i < got8.size()) begin
                n_vec++;
                if (got8[i].win !== exp_q[i].win || got8[i].x != exp_q[i].x || got8[i].y != exp_q[i].y ||
                    got8[i].last !== exp_q[i].last) begin
                    n_err++;
                    $display("FAIL mid_reset[%0d]: got w=%h (%0d,%0d) l=%b want w=%h (%0d,%0d) l=%b", i,
                             got8[i].win, got8[i].x, got8[i].y, got8[i].last,
                             exp_q[i].win, exp_q[i].x, exp_q[i].y, exp_q[i].last);
                end
            end
        end
    endtask

    task automatic test_min_size();
        for (int pass = 0; pass < 3; pass++) begin
            fill_random();
            build_model(3, 3);
            got3.delete();
            beat3.delete();
            drive_frame(1'b1, (pass == 2) ? 50 : 0, 9);
            idle(6);
            n_vec++;
            if (got3.size() != 1) begin
                n_err++;
                $display("FAIL min_size count[%0d]: got %0d want 1", pass, got3.size());
            end else begin
                int want = (beat3.size() == 9) ? beat3[8] + 2 : -1;
                n_vec++;
                if (got3[0].win !== exp_q[0].win || got3[0].x != 1 || got3[0].y != 1 ||
                    got3[0].last !== 1'b1 || got3[0].cyc != want) begin
                    n_err++;
                    $display("FAIL min_size[%0d]: got w=%h (%0d,%0d) l=%b t=%0d want w=%h (1,1) l=1 t=%0d",
                             pass, got3[0].win, got3[0].x, got3[0].y, got3[0].last, got3[0].cyc,
                             exp_q[0].win, want);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_single_one();
        test_random_gaps();
        test_two_frames();
        test_reset_mid_frame();
        test_min_size();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
